movo_fsm: RTL and testbench

- Register-to-bus read sequencer for the microcontroller datapath; the reading counterpart of the immediate-move (register write) FSM.
- On start, it decodes a source selector and enables exactly one register's tri-state output onto the shared 16-bit bus.
- It captures the bus value into an internal holding register, exposes it on dout and reports completion on done.
- It sits beside the other instruction FSMs and is sequenced by the control unit through start/done and donefetch.

---
 rtl/movo_fsm_pkg.sv | 22 ++
 rtl/movo_fsm_if.sv | 28 ++
 rtl/movo_src_decode.sv | 32 +++
 rtl/movo_fsm.sv | 71 +++++++
 tb/tb_movo_fsm.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/movo_fsm_pkg.sv
// rtl/movo_fsm_pkg.sv - shared microcontroller constants for the instruction FSMs
package movo_fsm_pkg;

    // Datapath width shared by the register file, bus and instruction FSMs
    localparam int MC_DATA_W = 16;

    // Instruction FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_LOAD  = 3'b001;
    localparam logic [2:0] ST_DRIVE = 3'b010;
    localparam logic [2:0] ST_CAPT  = 3'b011;
    localparam logic [2:0] ST_DONE  = 3'b100;
    localparam logic [2:0] ST_ERR   = 3'b101;

    // Register-select codes used by parameter1
    localparam int REG_R0 = 0;
    localparam int REG_R1 = 1;
    localparam int REG_R2 = 2;
    localparam int REG_R3 = 3;
    localparam int REG_P0 = 4;

endpackage

// File: rtl/movo_fsm_if.sv
// rtl/movo_fsm_if.sv - control/bus handshake bundle for the register read sequencer
interface movo_fsm_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 6
);
    logic              donefetch;
    logic              start;
    logic [SEL_W-1:0]  parameter1;
    logic [DATA_W-1:0] bus;
    logic              r0out;
    logic              r1out;
    logic              r2out;
    logic              r3out;
    logic              P0out;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              err;

    modport master (
        output donefetch, start, parameter1, bus,
        input  r0out, r1out, r2out, r3out, P0out, dout, done, err
    );

    modport slave (
        input  donefetch, start, parameter1, bus,
        output r0out, r1out, r2out, r3out, P0out, dout, done, err
    );
endinterface

// File: rtl/movo_src_decode.sv
// rtl/movo_src_decode.sv - selector to one-hot register output-enable decoder
module movo_src_decode
    import movo_fsm_pkg::*;
#(
    parameter int SEL_W = 6
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic             r0out,
    output logic             r1out,
    output logic             r2out,
    output logic             r3out,
    output logic             P0out
);

    // One enable at most; illegal codes and en=0 leave the bus undriven
    always_comb begin
        r0out = 1'b0;
        r1out = 1'b0;
        r2out = 1'b0;
        r3out = 1'b0;
        P0out = 1'b0;
        if (en) begin
            r0out = (sel == SEL_W'(REG_R0));
            r1out = (sel == SEL_W'(REG_R1));
            r2out = (sel == SEL_W'(REG_R2));
            r3out = (sel == SEL_W'(REG_R3));
            P0out = (sel == SEL_W'(REG_P0));
        end
    end

endmodule

// File: rtl/movo_fsm.sv
// rtl/movo_fsm.sv - register-to-bus read sequencer (move-out FSM)
module movo_fsm
    import movo_fsm_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int SEL_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    movo_fsm_if.slave  io
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] dout_q;
    logic              drive_en;

    // Next-state logic; donefetch aborts from any state and beats start
    always_comb begin
        state_nxt = ST_IDLE;
        if (!io.donefetch) begin
            case (state)
                ST_IDLE:  state_nxt = io.start ? ST_LOAD : ST_IDLE;
                ST_LOAD:  state_nxt = (io.parameter1 > SEL_W'(REG_P0)) ? ST_ERR : ST_DRIVE;
                ST_DRIVE: state_nxt = ST_CAPT;
                ST_CAPT:  state_nxt = ST_DONE;
                ST_DONE:  state_nxt = io.start ? ST_DONE : ST_IDLE;
                ST_ERR:   state_nxt = io.start ? ST_ERR : ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, selector latch in LOAD and bus capture on the CAPT->DONE edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            sel_q  <= '0;
            dout_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_LOAD && !io.donefetch) begin
                sel_q <= io.parameter1;
            end
            if (state == ST_CAPT && !io.donefetch) begin
                dout_q <= io.bus;
            end
        end
    end

    // Enables come from state and sel_q only, never from parameter1 directly
    assign drive_en = (state == ST_DRIVE) || (state == ST_CAPT);

    movo_src_decode #(
        .SEL_W (SEL_W)
    ) u_src_decode (
        .sel   (sel_q),
        .en    (drive_en),
        .r0out (io.r0out),
        .r1out (io.r1out),
        .r2out (io.r2out),
        .r3out (io.r3out),
        .P0out (io.P0out)
    );

    assign io.dout = dout_q;
    assign io.done = (state == ST_DONE) || (state == ST_ERR);
    assign io.err  = (state == ST_ERR);

endmodule

// File: tb/tb_movo_fsm.sv
// tb/tb_movo_fsm.sv - self-checking bench for movo_fsm
module tb_movo_fsm;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] ref_dout;

    movo_fsm_if #(.DATA_W(16), .SEL_W(6)) io ();

    movo_fsm #(.DATA_W(16), .SEL_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] en;
    assign en = {io.P0out, io.r3out, io.r2out, io.r1out, io.r0out};

    typedef struct {
        logic [5:0]  sel;
        logic [15:0] bus;
        logic [4:0]  en;
        logic        err;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] en_e, input logic done_e,
                           input logic err_e, input logic [15:0] dout_e);
        chk({name, ".en"},   {27'd0, en},      {27'd0, en_e});
        chk({name, ".done"}, {31'd0, io.done}, {31'd0, done_e});
        chk({name, ".err"},  {31'd0, io.err},  {31'd0, err_e});
        chk({name, ".dout"}, {16'd0, io.dout}, {16'd0, dout_e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        io.parameter1 = v.sel;
        io.bus        = v.bus;
        io.start      = 1'b1;
        cyc();
        chk_all({nm, ".load"}, 5'd0, 1'b0, 1'b0, ref_dout);
        if (v.err) begin
            cyc();
            chk_all({nm, ".err"}, 5'd0, 1'b1, 1'b1, v.dout);
            cyc();
            chk_all({nm, ".errhold"}, 5'd0, 1'b1, 1'b1, v.dout);
        end else begin
            cyc();
            chk_all({nm, ".drive"}, v.en, 1'b0, 1'b0, ref_dout);
            cyc();
            chk_all({nm, ".capt"}, v.en, 1'b0, 1'b0, ref_dout);
            cyc();
            chk_all({nm, ".done"}, 5'd0, 1'b1, 1'b0, v.dout);
        end
        io.start = 1'b0;
        cyc();
        chk_all({nm, ".idle"}, 5'd0, 1'b0, 1'b0, v.dout);
        ref_dout = v.dout;
    endtask

    initial begin
        logic [5:0]  sel;
        logic [15:0] bv;
        logic        legal;
        logic        early;
        int          abort;
        int          done_k;
        int          last_k;
        logic [4:0]  en_e;
        logic        done_e;
        logic        err_e;

        checks = 0;
        errors = 0;
        ref_dout = 16'h0;
        rst = 1'b0;
        io.donefetch  = 1'b0;
        io.start      = 1'b0;
        io.parameter1 = 6'd0;
        io.bus        = 16'h0;

        tbl[0] = '{6'd2,  16'hA5C3, 5'b00100, 1'b0, 16'hA5C3};
        tbl[1] = '{6'd4,  16'h003F, 5'b10000, 1'b0, 16'h003F};
        tbl[2] = '{6'd9,  16'hFFFF, 5'b00000, 1'b1, 16'h003F};
        tbl[3] = '{6'd0,  16'h1111, 5'b00001, 1'b0, 16'h1111};
        tbl[4] = '{6'd1,  16'h2222, 5'b00010, 1'b0, 16'h2222};
        tbl[5] = '{6'd3,  16'h3333, 5'b01000, 1'b0, 16'h3333};
        tbl[6] = '{6'd5,  16'h4444, 5'b00000, 1'b1, 16'h3333};
        tbl[7] = '{6'd63, 16'h5555, 5'b00000, 1'b1, 16'h3333};

        // Reset state
        cyc();
        cyc();
        chk_all("reset", 5'd0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk_all("post_reset", 5'd0, 1'b0, 1'b0, 16'h0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], i);
        end

        // Async reset mid-DRIVE
        io.parameter1 = 6'd3;
        io.bus        = 16'hBEEF;
        io.start      = 1'b1;
        cyc();
        cyc();
        chk_all("rst_mid.drive", 5'b01000, 1'b0, 1'b0, ref_dout);
        rst = 1'b0;
        #1;
        chk_all("rst_mid.async", 5'd0, 1'b0, 1'b0, 16'h0);
        ref_dout = 16'h0;
        io.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk_all("rst_mid.idle", 5'd0, 1'b0, 1'b0, 16'h0);
        cyc();
        chk_all("rst_mid.idle2", 5'd0, 1'b0, 1'b0, 16'h0);

        // Abort in CAPT right after reset: dout must stay 0, done never seen
        io.parameter1 = 6'd1;
        io.bus        = 16'h1234;
        io.start      = 1'b1;
        cyc();
        cyc();
        cyc();
        chk_all("abort.capt", 5'b00010, 1'b0, 1'b0, 16'h0);
        io.donefetch = 1'b1;
        io.start     = 1'b0;
        cyc();
        chk_all("abort.idle", 5'd0, 1'b0, 1'b0, 16'h0);
        io.donefetch = 1'b0;
        cyc();
        chk_all("abort.idle2", 5'd0, 1'b0, 1'b0, 16'h0);

        // Selector change after LOAD is ignored
        io.parameter1 = 6'd1;
        io.bus        = 16'h7E81;
        io.start      = 1'b1;
        cyc();
        cyc();
        chk_all("selchg.drive", 5'b00010, 1'b0, 1'b0, 16'h0);
        io.parameter1 = 6'd3;
        cyc();
        chk_all("selchg.capt", 5'b00010, 1'b0, 1'b0, 16'h0);
        cyc();
        chk_all("selchg.done", 5'd0, 1'b1, 1'b0, 16'h7E81);
        io.start = 1'b0;
        cyc();
        chk_all("selchg.idle", 5'd0, 1'b0, 1'b0, 16'h7E81);
        ref_dout = 16'h7E81;

        // Randomized transactions against a cycle-schedule reference model
        for (int t = 0; t < 60; t++) begin
            sel    = 6'($urandom_range(0, 7));
            bv     = 16'($urandom);
            legal  = (sel <= 6'd4);
            early  = ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, legal ? 3 : 1)) : 0;
            done_k = legal ? 4 : 2;
            if (abort != 0)
                last_k = abort + 1;
            else if (early)
                last_k = done_k + 1;
            else
                last_k = done_k + 2;

            io.parameter1 = sel;
            io.bus        = bv;
            io.start      = 1'b1;
            for (int k = 1; k <= last_k; k++) begin
                cyc();
                en_e   = 5'd0;
                done_e = 1'b0;
                err_e  = 1'b0;
                if (abort != 0 && k > abort) begin
                    en_e = 5'd0;
                end else if (k < done_k) begin
                    if (legal && k >= 2)
                        en_e = 5'(1 << sel);
                end else if (k == done_k || (k == done_k + 1 && !early)) begin
                    done_e = 1'b1;
                    err_e  = !legal;
                    if (legal && k == done_k)
                        ref_dout = bv;
                end
                chk_all($sformatf("rnd%0d.k%0d", t, k), en_e, done_e, err_e, ref_dout);

                if (k == 1 && early)
                    io.start = 1'b0;
                if (k == 2)
                    io.parameter1 = 6'($urandom_range(0, 63));
                if (k == abort) begin
                    io.donefetch = 1'b1;
                    io.start     = 1'b0;
                end
                if (abort != 0 && k == abort + 1)
                    io.donefetch = 1'b0;
                if (abort == 0 && !early && k == done_k + 1)
                    io.start = 1'b0;
            end
            io.donefetch = 1'b0;
            io.start     = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
